// File: rtl/t_counter_pkg.sv
// Shared types and constants for the T-cell counter controller.
//   state_t  : controller FSM state (IDLE / RUN), 1-bit encoding
//   DIR_UP   : DIR value selecting count-up
//   DIR_DOWN : DIR value selecting count-down
package t_counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/t_flip_flop.sv
// Single clocked T cell: toggles its state when T is high at a rising edge.
//   CLK   : rising-edge clock
//   RST   : synchronous active-high reset, forces Q to 0
//   T     : toggle request for this edge
//   Q     : cell state
//   not_Q : complement of Q
module t_flip_flop (
   input  logic CLK,
   input  logic RST,
   input  logic T,
   output logic Q,
   output logic not_Q
);

   always_ff @(posedge CLK) begin
      if (RST) Q <= 1'b0;
      else     Q <= Q ^ T;
   end

   assign not_Q = ~Q;

endmodule

// File: rtl/t_counter_controller.sv
// Sequencer for a bank of WIDTH T cells acting as a programmable counter.
// Each cycle the toggle vector T_VEC is derived from the bank state and the
// commands, producing hold, count-up, count-down or parallel load.
//   CLK, RST       : clock, synchronous active-high reset
//   EN, DIR        : count enable, direction (1 up / 0 down)
//   START, STOP    : IDLE->RUN / RUN->IDLE requests
//   LOAD, LOAD_VAL : parallel-load request and value
//   Q, not_Q       : T-cell bank state and its complement
//   T_VEC          : toggle vector applied at the coming edge
//   BUSY           : state is RUN
//   TC             : registered one-cycle terminal-count pulse
//
// state | meaning
// IDLE  | bank holds; only LOAD changes Q; START arms counting
// RUN   | one step per enabled cycle in the DIR direction
module t_counter_controller
   import t_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int ONE_SHOT = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIR,
   input  logic             START,
   input  logic             STOP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] not_Q,
   output logic [WIDTH-1:0] T_VEC,
   output logic             BUSY,
   output logic             TC
);

   state_t           state_q;
   state_t           state_d;
   logic             count_step;
   logic             hit_term;
   logic             tc_d;
   logic [WIDTH-1:0] up_vec;
   logic [WIDTH-1:0] dn_vec;
   logic [WIDTH-1:0] lo_mask;
   logic [WIDTH-1:0] terminal;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_flip_flop u_cell (
         .CLK   (CLK),
         .RST   (RST),
         .T     (T_VEC[i]),
         .Q     (Q[i]),
         .not_Q (not_Q[i])
      );
   end

   // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always.
   always_comb begin
      up_vec  = '0;
      dn_vec  = '0;
      lo_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lo_mask   = (WIDTH'(1) << i) - WIDTH'(1);
         up_vec[i] = &(Q | ~lo_mask);
         dn_vec[i] = &(~Q | ~lo_mask);
      end
   end

   // LOAD and STOP both suppress the count step in RUN.
   assign count_step = (state_q == RUN) && !LOAD && !STOP && EN;
   assign terminal   = (DIR == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   assign hit_term   = ((Q ^ T_VEC) == terminal);
   assign tc_d       = count_step && hit_term;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         TC      <= 1'b0;
      end else begin
         state_q <= state_d;
         TC      <= tc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!LOAD) begin
         case (state_q)
            IDLE: if (!STOP && START) state_d = RUN;
            RUN: begin
               if (STOP)                           state_d = IDLE;
               else if (tc_d && (ONE_SHOT != 0))   state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      BUSY  = (state_q == RUN);
      T_VEC = '0;
      if (LOAD)            T_VEC = Q ^ LOAD_VAL;
      else if (count_step) T_VEC = (DIR == DIR_UP) ? up_vec : dn_vec;
   end

endmodule

// File: tb/tb_t_counter_controller.sv
module tb_t_counter_controller;

   typedef struct {
      int         dut;
      bit         chk_tv;
      logic [3:0] tv;
      logic [3:0] q;
      logic       busy;
      logic       tc;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] rst = '0, en = '0, dir = '0, start = '0, stop = '0, load = '0;
   logic [3:0] lval [2];
   logic [3:0] q [2];
   logic [3:0] nq [2];
   logic [3:0] tv [2];
   logic [1:0] busy, tc;

   exp_t sb [$];
   int   checks = 0;
   int   failures = 0;
   bit   have_pend = 0;
   exp_t pend;

   always #5 clk = ~clk;

   t_counter_controller #(.WIDTH(4), .ONE_SHOT(0)) u_free (
      .CLK(clk), .RST(rst[0]), .EN(en[0]), .DIR(dir[0]), .START(start[0]),
      .STOP(stop[0]), .LOAD(load[0]), .LOAD_VAL(lval[0]), .Q(q[0]),
      .not_Q(nq[0]), .T_VEC(tv[0]), .BUSY(busy[0]), .TC(tc[0]));

   t_counter_controller #(.WIDTH(4), .ONE_SHOT(1)) u_shot (
      .CLK(clk), .RST(rst[1]), .EN(en[1]), .DIR(dir[1]), .START(start[1]),
      .STOP(stop[1]), .LOAD(load[1]), .LOAD_VAL(lval[1]), .Q(q[1]),
      .not_Q(nq[1]), .T_VEC(tv[1]), .BUSY(busy[1]), .TC(tc[1]));

   task automatic chk(input string nm, input string what, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s %s: got %h expected %h", nm, what, act, req);
      end
   endtask

   // Monitor: inputs settle at negedge+1; at negedge+3 the previous item's
   // post-edge state is visible and the new item's T_VEC is combinational.
   initial begin
      exp_t cur;
      forever begin
         @(negedge clk);
         #3;
         if (have_pend) begin
            chk(pend.name, "Q",     q[pend.dut],  pend.q);
            chk(pend.name, "not_Q", nq[pend.dut], ~pend.q);
            chk(pend.name, "BUSY",  {3'b0, busy[pend.dut]}, {3'b0, pend.busy});
            chk(pend.name, "TC",    {3'b0, tc[pend.dut]},   {3'b0, pend.tc});
            have_pend = 0;
         end
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.chk_tv) chk(cur.name, "T_VEC", tv[cur.dut], cur.tv);
            pend      = cur;
            have_pend = 1;
         end
      end
   end

   task automatic step(input int d, input logic r, e, di, s, p, l, input logic [3:0] lv,
                       input bit ct, input logic [3:0] etv, eq, input logic eb, et,
                       input string nm);
      exp_t x;
      @(negedge clk);
      #1;
      rst[d] = r; en[d] = e; dir[d] = di; start[d] = s; stop[d] = p; load[d] = l;
      lval[d] = lv;
      x.dut = d; x.chk_tv = ct; x.tv = etv; x.q = eq; x.busy = eb; x.tc = et; x.name = nm;
      sb.push_back(x);
   endtask

   initial begin
      lval[0] = '0;
      lval[1] = '0;

      // free-running instance: reset with START and LOAD also asserted
      step(0, 1,0,0,1,0,1, 4'h5, 0, 4'h0, 4'h0, 0, 0, "rst1");
      step(0, 1,0,0,1,0,1, 4'h5, 1, 4'h5, 4'h0, 0, 0, "rst2");

      // up count with wrap
      step(0, 0,1,1,1,0,0, 4'h0, 1, 4'h0, 4'h0, 1, 0, "start_up");
      for (int i = 1; i <= 16; i++)
         step(0, 0,1,1,0,0,0, 4'h0, 1, 4'(i-1) ^ 4'(i), 4'(i), 1, (i == 15), "up_wrap");

      for (int i = 1; i <= 5; i++)
         step(0, 0,1,1,0,0,0, 4'h0, 1, 4'(i-1) ^ 4'(i), 4'(i), 1, 0, "up_to5");

      // enable gating
      for (int i = 0; i < 3; i++)
         step(0, 0,0,1,0,0,0, 4'h0, 1, 4'h0, 4'h5, 1, 0, "en_hold");
      step(0, 0,1,1,0,0,0, 4'h0, 1, 4'h3, 4'h6, 1, 0, "en_resume");

      // LOAD beats STOP; then STOP alone
      step(0, 0,1,1,0,1,1, 4'hA, 1, 4'hC, 4'hA, 1, 0, "load_stop");
      step(0, 0,1,1,0,1,0, 4'h0, 1, 4'h0, 4'hA, 0, 0, "stop");
      step(0, 0,1,1,0,0,0, 4'h0, 1, 4'h0, 4'hA, 0, 0, "idle_hold");
      step(0, 0,1,1,0,0,1, 4'h7, 1, 4'hD, 4'h7, 0, 0, "idle_load");
      step(0, 0,0,1,1,0,0, 4'h0, 1, 4'h0, 4'h7, 1, 0, "start7");

      // reset mid-run, resume from 0
      step(0, 1,1,1,0,0,0, 4'h0, 0, 4'h0, 4'h0, 0, 0, "rst_mid");
      step(0, 0,1,1,1,0,0, 4'h0, 1, 4'h0, 4'h0, 1, 0, "restart");
      step(0, 0,1,1,0,0,0, 4'h0, 1, 4'h1, 4'h1, 1, 0, "resume_up");

      // direction change, down wrap in free-run, load to terminal gives no TC
      step(0, 0,1,0,0,0,0, 4'h0, 1, 4'h1, 4'h0, 1, 1, "down_term");
      step(0, 0,1,0,0,0,0, 4'h0, 1, 4'hF, 4'hF, 1, 0, "down_wrap");
      step(0, 0,1,0,0,0,1, 4'h0, 1, 4'hF, 4'h0, 1, 0, "load_term");

      // one-shot instance: down count from 3
      step(1, 1,0,0,1,0,1, 4'h3, 0, 4'h0, 4'h0, 0, 0, "os_rst");
      step(1, 0,0,0,0,0,1, 4'h3, 1, 4'h3, 4'h3, 0, 0, "os_load3");
      step(1, 0,1,0,1,0,0, 4'h0, 1, 4'h0, 4'h3, 1, 0, "os_start");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'h1, 4'h2, 1, 0, "os_dn2");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'h3, 4'h1, 1, 0, "os_dn1");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'h1, 4'h0, 0, 1, "os_dn0");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'h0, 4'h0, 0, 0, "os_hold");

      // one-shot start already at terminal: first step wraps
      step(1, 0,1,0,1,0,0, 4'h0, 1, 4'h0, 4'h0, 1, 0, "os_restart");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'hF, 4'hF, 1, 0, "os_wrap");
      step(1, 0,1,0,0,0,0, 4'h0, 1, 4'h1, 4'hE, 1, 0, "os_dnE");

      begin
         int budget = 20;
         while ((sb.size() > 0 || have_pend) && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         #5;
         if (sb.size() > 0 || have_pend) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d items left, expected 0", sb.size() + int'(have_pend));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
